// File: rtl/pmod_ad1_pkg.sv
`default_nettype none
// ============================================================================
//  pmod_ad1_pkg : shared widths, write-side FSM states and word packing
//  Revision 1.0
// ============================================================================
package pmod_ad1_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 2 * SAMPLE_W;
    localparam int ENTRY_W  = WORD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [SAMPLE_W-1:0] d0,
        input logic [SAMPLE_W-1:0] d1
    );
        return {d1, d0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmod_ad1_sfifo.sv
`default_nettype none
// ============================================================================
//  pmod_ad1_sfifo : synchronous first-word-fall-through FIFO with level
//  Revision 1.0
// ============================================================================
module pmod_ad1_sfifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Flags come from registered pointers, so a pop cannot free room for a same-cycle push.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/pmod_ad1_framer.sv
`default_nettype none
// ============================================================================
//  pmod_ad1_framer : packs ADC sample pairs into 32-bit AXI4-Stream frames
//  Revision 1.0
// ============================================================================
module pmod_ad1_framer
    import pmod_ad1_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int FRAME_LEN_W = 16
) (
    input  logic                          AXI_ACLK_i,
    input  logic                          AXI_ARESETN_i,
    input  logic [SAMPLE_W-1:0]           ADC_DATA0_i,
    input  logic [SAMPLE_W-1:0]           ADC_DATA1_i,
    input  logic                          ADC_VALID_i,
    input  logic                          ENABLE_i,
    input  logic [FRAME_LEN_W-1:0]        FRAME_LEN_i,
    input  logic                          CLR_i,
    output logic [WORD_W-1:0]             AXIS_TDATA_o,
    output logic [3:0]                    AXIS_TKEEP_o,
    output logic                          AXIS_TLAST_o,
    output logic                          AXIS_TVALID_o,
    input  logic                          AXIS_TREADY_i,
    output logic                          BUSY_o,
    output logic                          OVF_o,
    output logic [15:0]                   DROP_CNT_o,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL_o
);
    state_e                   state_q, state_d;
    logic [FRAME_LEN_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_LEN_W-1:0]   frame_len_q, frame_len_d;
    logic [15:0]              drop_cnt_q, drop_cnt_d;
    logic                     ovf_q, ovf_d;

    logic                     fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]       fifo_dout;
    logic [FRAME_LEN_W-1:0]   len_sel, cur_len;
    logic                     active, accept, drop, last;

    // A new frame picks up the live FRAME_LEN_i on its first word; zero means one.
    assign len_sel = (FRAME_LEN_i == '0) ? FRAME_LEN_W'(1) : FRAME_LEN_i;
    assign cur_len = (cnt_q == '0) ? len_sel : frame_len_q;
    assign last    = (cnt_q == cur_len - FRAME_LEN_W'(1));
    assign active  = (state_q != ST_IDLE);
    assign accept  = ADC_VALID_i && active && !fifo_full;
    assign drop    = ADC_VALID_i && active && fifo_full;

    always_comb begin
        cnt_d       = cnt_q;
        frame_len_d = frame_len_q;
        drop_cnt_d  = drop_cnt_q;
        ovf_d       = ovf_q;
        if (state_q == ST_IDLE && ENABLE_i) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = last ? '0 : cnt_q + FRAME_LEN_W'(1);
            if (cnt_q == '0) frame_len_d = len_sel;
        end
        if (CLR_i) begin
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge AXI_ACLK_i or negedge AXI_ARESETN_i) begin
        if (!AXI_ARESETN_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            frame_len_q <= FRAME_LEN_W'(1);
            drop_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_len_q <= frame_len_d;
            drop_cnt_q  <= drop_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // Leaving RUN/STOP looks at the post-accept count so a frame is never cut short.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ENABLE_i) state_d = ST_RUN;
            ST_RUN:  if (!ENABLE_i) state_d = (cnt_d == '0) ? ST_IDLE : ST_STOP;
            ST_STOP: begin
                if (ENABLE_i)           state_d = ST_RUN;
                else if (cnt_d == '0)   state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY_o = (state_q != ST_IDLE);
    end

    pmod_ad1_sfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (AXI_ACLK_i),
        .rst_n   (AXI_ARESETN_i),
        .push_i  (accept),
        .din_i   ({last, pack_word(ADC_DATA0_i, ADC_DATA1_i)}),
        .pop_i   (AXIS_TREADY_i),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (FIFO_LEVEL_o)
    );

    assign AXIS_TVALID_o = !fifo_empty;
    assign AXIS_TDATA_o  = fifo_dout[WORD_W-1:0];
    assign AXIS_TLAST_o  = fifo_dout[WORD_W];
    assign AXIS_TKEEP_o  = 4'hF;
    assign OVF_o         = ovf_q;
    assign DROP_CNT_o    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pmod_ad1_framer.sv
`default_nettype none
// ============================================================================
//  tb_pmod_ad1_framer : randomized self-checking bench with a queue-based model
//  Revision 1.0
// ============================================================================
module tb_pmod_ad1_framer;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] d0, d1;
    logic        valid, en, clr, tready;
    logic [15:0] flen;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tvalid, busy, ovf;
    logic [15:0] drop_cnt;
    logic [LW-1:0] level;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words waiting in the FIFO, in order, with their TLAST bit.
    logic [32:0] mq[$];
    bit          m_busy;
    int          m_pos, m_len, m_drops;
    bit          m_ovf;
    bit          rand_rdy;

    pmod_ad1_framer #(.FIFO_DEPTH(DEPTH), .FRAME_LEN_W(16)) dut (
        .AXI_ACLK_i    (clk),
        .AXI_ARESETN_i (rst_n),
        .ADC_DATA0_i   (d0),
        .ADC_DATA1_i   (d1),
        .ADC_VALID_i   (valid),
        .ENABLE_i      (en),
        .FRAME_LEN_i   (flen),
        .CLR_i         (clr),
        .AXIS_TDATA_o  (tdata),
        .AXIS_TKEEP_o  (tkeep),
        .AXIS_TLAST_o  (tlast),
        .AXIS_TVALID_o (tvalid),
        .AXIS_TREADY_i (tready),
        .BUSY_o        (busy),
        .OVF_o         (ovf),
        .DROP_CNT_o    (drop_cnt),
        .FIFO_LEVEL_o  (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy  = 0;
        m_pos   = 0;
        m_len   = 1;
        m_drops = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step();
        int  sz;
        bit  lst;
        bit  do_pop;
        sz     = mq.size();
        do_pop = (sz > 0) && tready;
        if (m_busy && valid) begin
            if (sz < DEPTH) begin
                if (m_pos == 0) m_len = (flen == 0) ? 1 : int'(flen);
                lst = (m_pos == m_len - 1);
                mq.push_back({lst, d1, d0});
                m_pos = lst ? 0 : m_pos + 1;
            end else begin
                if (m_drops < 65535) m_drops++;
                m_ovf = 1;
            end
        end
        if (clr) begin
            m_drops = 0;
            m_ovf   = 0;
        end
        if (do_pop) void'(mq.pop_front());
        if (!m_busy) begin
            if (en) begin
                m_busy = 1;
                m_pos  = 0;
            end
        end else if (!en && m_pos == 0) begin
            m_busy = 0;
        end
    endtask

    task automatic check_outputs();
        chk("tvalid", 64'(tvalid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("tdata", 64'(tdata), 64'(mq[0][31:0]));
            chk("tlast", 64'(tlast), 64'(mq[0][32]));
        end
        chk("level", 64'(level), 64'(mq.size()));
        chk("level_bound", 64'(level <= DEPTH), 64'd1);
        chk("busy", 64'(busy), 64'(m_busy));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
        chk("tkeep", 64'(tkeep), 64'hF);
    endtask

    task automatic tick();
        if (rand_rdy) tready = 1'($urandom_range(0, 1));
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe();
        valid = 1'b1;
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        tick();
        valid = 1'b0;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) strobe();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
        chk({tag, "_tdata"},  64'(tdata),  64'd0);
        chk({tag, "_tlast"},  64'(tlast),  64'd0);
        chk({tag, "_busy"},   64'(busy),   64'd0);
        chk({tag, "_ovf"},    64'(ovf),    64'd0);
        chk({tag, "_drop"},   64'(drop_cnt), 64'd0);
        chk({tag, "_level"},  64'(level),  64'd0);
        chk({tag, "_tkeep"},  64'(tkeep),  64'hF);
    endtask

    initial begin
        rst_n = 1'b0; valid = 0; en = 0; clr = 0; tready = 0;
        flen = 16'd4; d0 = 0; d1 = 0; rand_rdy = 0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        ticks(2);

        // 1: two 4-word frames streamed straight out
        en = 1; tready = 1; flen = 16'd4;
        tick();
        strobes(8);
        ticks(3);

        // 2: overflow with the sink stalled, then drain and clear
        tready = 0;
        strobes(11);
        chk("t2_level", 64'(level), 64'd8);
        chk("t2_drop", 64'(drop_cnt), 64'd3);
        chk("t2_ovf", 64'(ovf), 64'd1);
        tready = 1;
        ticks(10);
        chk("t2_drained", 64'(level), 64'd0);
        clr = 1; tick(); clr = 0;
        chk("t2_clr", 64'(drop_cnt), 64'd0);

        // 3: disable mid-frame, frame still completes
        en = 0; ticks(2);
        chk("t3_idle", 64'(busy), 64'd0);
        flen = 16'd5; en = 1; tick();
        strobes(2);
        en = 0; tick();
        chk("t3_stop_busy", 64'(busy), 64'd1);
        strobes(3);
        chk("t3_done_busy", 64'(busy), 64'd0);
        strobes(3);
        ticks(4);
        chk("t3_ignored", 64'(level), 64'd0);

        // 4: frame length change mid-frame, then zero length
        flen = 16'd4; en = 1; tick();
        strobes(2);
        flen = 16'd6;
        strobes(2);
        strobes(6);
        flen = 16'd0;
        strobes(3);
        ticks(4);

        // 5: random throttling, gaps and frame lengths
        rand_rdy = 1;
        flen = 16'd3;
        for (int s = 0; s < 1000; s++) begin
            if (s % 100 == 0) flen = 16'($urandom_range(0, 7));
            ticks($urandom_range(0, 2));
            strobe();
        end
        rand_rdy = 0;
        tready = 1;
        ticks(12);

        // 6: asynchronous reset with the FIFO half full mid-frame
        tready = 0; flen = 16'd5;
        strobes(4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        model_reset();
        en = 0; valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        en = 1; tready = 1; tick();
        strobes(10);
        ticks(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
